// File: rtl/fir_window_buffer_pkg.sv
// Shared definitions for the FIR window buffer.
// The only shared item is a constant ceil(log2) helper. Blocks use it to size
// channel pointers and fill counters from their parameters.
package fir_window_buffer_pkg;

    // ceil(log2(v)). Returns 0 for v <= 1. Callers clamp the result where a
    // zero width would be illegal.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_window_buffer_bank.sv
// Per-channel sample window storage.
// The bank holds CH windows of MEM_LEN samples each. The channel selected by
// sel_i is shifted combinationally: the P oldest samples are retired and
// din_i is inserted at the MSB end. The shifted window appears on win_o and
// is committed to storage when we_i is high. clr_i zeroes every window.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset, zeroes all windows
//   clr_i  synchronous clear, zeroes all windows
//   we_i   commit the shifted window to channel sel_i
//   sel_i  channel select
//   din_i  P-sample batch; the lowest slot is the oldest sample
//   win_o  post-shift window of channel sel_i; the lowest slot is the oldest sample
module fir_window_buffer_bank #(
    parameter int CH      = 1,
    parameter int CH_W    = 1,
    parameter int MEM_LEN = 21,
    parameter int NB      = 18,
    parameter int P       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [CH_W-1:0]       sel_i,
    input  logic [P*NB-1:0]       din_i,
    output logic [MEM_LEN*NB-1:0] win_o
);
    localparam int W = MEM_LEN * NB;

    logic [CH-1:0][W-1:0] win_q, win_d;
    logic [W-1:0]         cur;
    logic [W-1:0]         shifted;

    // A loop mux never indexes past CH-1 when CH is not a power of 2.
    always_comb begin
        cur = '0;
        for (int c = 0; c < CH; c++) begin
            if (sel_i == CH_W'(c)) cur = win_q[c];
        end
    end

    // When N=1, the window holds exactly one batch, so the whole window is replaced.
    generate
        if (MEM_LEN == P) begin : g_full
            assign shifted = din_i;
        end else begin : g_shift
            assign shifted = {din_i, cur[W-1:P*NB]};
        end
    endgenerate

    assign win_o = shifted;

    always_comb begin
        win_d = win_q;
        if (clr_i) begin
            win_d = '0;
        end else if (we_i) begin
            for (int c = 0; c < CH; c++) begin
                if (sel_i == CH_W'(c)) win_d[c] = shifted;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) win_q <= '0;
        else       win_q <= win_d;
    end

endmodule

// File: rtl/fir_window_buffer.sv
// Multi-channel, P-parallel sample window for the parallel FIR datapath.
// Channels are time-interleaved. Each accepted batch shifts the window of the
// channel that is next in round-robin order. The post-shift window is
// presented as a registered snapshot with a valid/ready handshake. The
// snapshot carries the channel tag and a primed flag, which is set once that
// window holds only real samples.
// Ports:
//   i_clock    clock, rising edge
//   i_reset    synchronous active-high reset
//   i_enable   global enable; when low, all state is frozen and o_ready is 0
//   i_flush    clears all windows, fill counts and the channel pointer
//   i_valid    input batch valid
//   o_ready    batch is accepted when i_valid & o_ready
//   i_data     P samples; [NB-1:0] is the oldest sample
//   o_valid    snapshot valid
//   i_ready    downstream ready
//   o_data     window snapshot; [NB-1:0] is the oldest sample, the MSB slot is the newest
//   o_channel  channel of the snapshot
//   o_primed   snapshot window is fully populated
module fir_window_buffer
    import fir_window_buffer_pkg::*;
#(
    parameter  int N           = 21,
    parameter  int NB          = 18,
    parameter  int PARALLELISM = 1,
    parameter  int CHANNELS    = 1,
    localparam int MEM_LEN     = N + PARALLELISM - 1,
    localparam int CH_W        = (CHANNELS > 1) ? clog2(CHANNELS) : 1,
    localparam int FILL_W      = clog2(MEM_LEN + 1)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [PARALLELISM*NB-1:0]  i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [MEM_LEN*NB-1:0]      o_data,
    output logic [CH_W-1:0]            o_channel,
    output logic                       o_primed
);
    logic [CH_W-1:0]                 ptr_q, ptr_d;
    logic [CHANNELS-1:0][FILL_W-1:0] fill_q, fill_d;
    logic                            valid_q, valid_d;
    logic [MEM_LEN*NB-1:0]           data_q, data_d;
    logic [CH_W-1:0]                 chan_q, chan_d;
    logic                            primed_q, primed_d;

    logic                  accept;
    logic                  clear;
    logic [MEM_LEN*NB-1:0] win_next;
    logic [FILL_W-1:0]     cur_fill;
    logic [FILL_W:0]       fill_sum;
    logic [FILL_W-1:0]     new_fill;

    // Single output stage with no skid buffer, so new input is taken only
    // when the output register is empty or is being drained in this cycle.
    assign o_ready = i_enable & ~i_flush & (~valid_q | i_ready);
    assign accept  = i_valid & o_ready;
    assign clear   = i_enable & i_flush;

    fir_window_buffer_bank #(
        .CH      (CHANNELS),
        .CH_W    (CH_W),
        .MEM_LEN (MEM_LEN),
        .NB      (NB),
        .P       (PARALLELISM)
    ) u_bank (
        .clk_i (i_clock),
        .rst_i (i_reset),
        .clr_i (clear),
        .we_i  (accept),
        .sel_i (ptr_q),
        .din_i (i_data),
        .win_o (win_next)
    );

    always_comb begin
        cur_fill = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ptr_q == CH_W'(c)) cur_fill = fill_q[c];
        end
    end

    // The sum carries one extra bit so the saturation compare cannot wrap.
    assign fill_sum = {1'b0, cur_fill} + (FILL_W+1)'(PARALLELISM);
    assign new_fill = (fill_sum >= (FILL_W+1)'(MEM_LEN)) ? FILL_W'(MEM_LEN)
                                                         : fill_sum[FILL_W-1:0];

    always_comb begin
        ptr_d    = ptr_q;
        fill_d   = fill_q;
        valid_d  = valid_q;
        data_d   = data_q;
        chan_d   = chan_q;
        primed_d = primed_q;
        if (clear) begin
            ptr_d   = '0;
            fill_d  = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ptr_q == CH_W'(c)) fill_d[c] = new_fill;
            end
            ptr_d    = (ptr_q == CH_W'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
            valid_d  = 1'b1;
            data_d   = win_next;
            chan_d   = ptr_q;
            primed_d = (new_fill == FILL_W'(MEM_LEN));
        end else if (valid_q && i_ready && i_enable) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ptr_q    <= '0;
            fill_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            chan_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            fill_q   <= fill_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            primed_q <= primed_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_channel = chan_q;
    assign o_primed  = primed_q;

endmodule

// File: tb/tb_fir_window_buffer.sv
module tb_fir_window_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b1, flush = 1'b0, rdy = 1'b1;

    // u1: N=4 P=1 CH=1
    logic v1 = 1'b0; logic [7:0]  d1 = '0;
    logic r1, ov1, ch1, pr1; logic [31:0] od1;
    // u2: N=4 P=2 CH=1
    logic v2 = 1'b0; logic [15:0] d2 = '0;
    logic r2, ov2, ch2, pr2; logic [39:0] od2;
    // u3: N=3 P=1 CH=3
    logic v3 = 1'b0; logic [7:0]  d3 = '0;
    logic r3, ov3, pr3; logic [1:0] ch3; logic [23:0] od3;
    // u4: N=4 P=1 CH=2
    logic v4 = 1'b0; logic [7:0]  d4 = '0;
    logic r4, ov4, ch4, pr4; logic [31:0] od4;

    fir_window_buffer #(.N(4), .NB(8), .PARALLELISM(1), .CHANNELS(1)) u1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(flush), .i_valid(v1),
        .o_ready(r1), .i_data(d1), .o_valid(ov1), .i_ready(rdy), .o_data(od1),
        .o_channel(ch1), .o_primed(pr1));
    fir_window_buffer #(.N(4), .NB(8), .PARALLELISM(2), .CHANNELS(1)) u2 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(flush), .i_valid(v2),
        .o_ready(r2), .i_data(d2), .o_valid(ov2), .i_ready(rdy), .o_data(od2),
        .o_channel(ch2), .o_primed(pr2));
    fir_window_buffer #(.N(3), .NB(8), .PARALLELISM(1), .CHANNELS(3)) u3 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(flush), .i_valid(v3),
        .o_ready(r3), .i_data(d3), .o_valid(ov3), .i_ready(rdy), .o_data(od3),
        .o_channel(ch3), .o_primed(pr3));
    fir_window_buffer #(.N(4), .NB(8), .PARALLELISM(1), .CHANNELS(2)) u4 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flush(flush), .i_valid(v4),
        .o_ready(r4), .i_data(d4), .o_valid(ov4), .i_ready(rdy), .o_data(od4),
        .o_channel(ch4), .o_primed(pr4));

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset ----
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid",  64'(ov1), 64'd0);
        chk("rst_data",   64'(od1), 64'd0);
        chk("rst_chan",   64'(ch3), 64'd0);
        chk("rst_primed", 64'(pr4), 64'd0);
        chk("rst_ready",  64'(r1),  64'd1);

        // ---- 1: N=4 P=1 CH=1, push 1..4 ----
        for (int i = 1; i <= 4; i++) begin
            v1 = 1'b1; d1 = 8'(i);
            step();
            chk("t1_valid",  64'(ov1), 64'd1);
            chk("t1_primed", 64'(pr1), (i == 4) ? 64'd1 : 64'd0);
            if (i == 1) chk("t1_first", 64'(od1), 64'h01000000);
        end
        chk("t1_data", 64'(od1), 64'h04030201);
        v1 = 1'b0;
        step();
        chk("t1_drain_valid", 64'(ov1), 64'd0);
        chk("t1_drain_hold",  64'(od1), 64'h04030201);

        // ---- 2: N=4 P=2 CH=1, MEM_LEN=5 ----
        v2 = 1'b1; d2 = 16'h0201;
        step();
        chk("t2_b1_data",   64'(od2), 64'h0201000000);
        chk("t2_b1_primed", 64'(pr2), 64'd0);
        d2 = 16'h0403;
        step();
        chk("t2_b2_data",   64'(od2), 64'h0403020100);
        chk("t2_b2_primed", 64'(pr2), 64'd0);
        d2 = 16'h0605;
        step();
        chk("t2_b3_data",   64'(od2), 64'h0605040302);
        chk("t2_b3_primed", 64'(pr2), 64'd1);
        v2 = 1'b0;

        // ---- 3: N=3 P=1 CH=3, push 10..18 ----
        for (int k = 0; k < 9; k++) begin
            v3 = 1'b1; d3 = 8'(10 + k);
            step();
            chk("t3_chan",   64'(ch3), 64'(k % 3));
            chk("t3_primed", 64'(pr3), (k >= 6) ? 64'd1 : 64'd0);
            if (k == 7) chk("t3_ch1_win", 64'(od3), 64'h110E0B);
        end
        v3 = 1'b0;

        // ---- 4: backpressure on u4 (N=4 P=1 CH=2) ----
        for (int i = 1; i <= 8; i++) begin
            v4 = 1'b1; d4 = 8'(i);
            step();
        end
        chk("t4_pre_data",   64'(od4), 64'h08060402);
        chk("t4_pre_primed", 64'(pr4), 64'd1);
        rdy = 1'b0; d4 = 8'h55;
        #1;
        chk("t4_ready_low", 64'(r4), 64'd0);
        for (int s = 0; s < 5; s++) begin
            step();
            chk("t4_stall_ready", 64'(r4),  64'd0);
            chk("t4_stall_valid", 64'(ov4), 64'd1);
            chk("t4_stall_data",  64'(od4), 64'h08060402);
            chk("t4_stall_chan",  64'(ch4), 64'd1);
        end
        rdy = 1'b1;
        step();
        chk("t4_release_data",   64'(od4), 64'h55070503);
        chk("t4_release_chan",   64'(ch4), 64'd0);
        chk("t4_release_primed", 64'(pr4), 64'd1);

        // ---- 5: flush drops the batch presented in the same cycle ----
        flush = 1'b1; d4 = 8'h66;
        #1;
        chk("t5_flush_ready", 64'(r4), 64'd0);
        step();
        chk("t5_flush_valid", 64'(ov4), 64'd0);
        flush = 1'b0; d4 = 8'h77;
        step();
        chk("t5_after_data",   64'(od4), 64'h77000000);
        chk("t5_after_chan",   64'(ch4), 64'd0);
        chk("t5_after_primed", 64'(pr4), 64'd0);
        d4 = 8'h88;
        step();
        chk("t5_ch1_cleared", 64'(od4), 64'h88000000);

        // ---- 6: reset pulse mid-stream, then enable low ----
        v4 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid",  64'(ov4), 64'd0);
        chk("t6_rst_data",   64'(od4), 64'd0);
        chk("t6_rst_chan",   64'(ch4), 64'd0);
        chk("t6_rst_primed", 64'(pr4), 64'd0);
        v4 = 1'b1; d4 = 8'h11;
        step();
        chk("t6_push_data", 64'(od4), 64'h11000000);
        chk("t6_push_chan", 64'(ch4), 64'd0);
        en = 1'b0; d4 = 8'h22;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("t6_dis_ready", 64'(r4),  64'd0);
            chk("t6_dis_valid", 64'(ov4), 64'd1);
            chk("t6_dis_data",  64'(od4), 64'h11000000);
        end
        en = 1'b1;
        step();
        chk("t6_resume_data", 64'(od4), 64'h22000000);
        chk("t6_resume_chan", 64'(ch4), 64'd1);
        v4 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
